// File: rtl/alu_pkg.sv
// Shared types for the bit-serial ALU sequencer: slice opcodes and sequencer states.
package alu_pkg;

  typedef enum logic [2:0] {
    OpPassB = 3'b000,
    OpRsvd1 = 3'b001,
    OpAdd   = 3'b010,
    OpSub   = 3'b011,
    OpAnd   = 3'b100,
    OpOr    = 3'b101,
    OpXor   = 3'b110,
    OpRsvd7 = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StDone = 2'b10
  } seq_state_e;

  // Only add/sub produce meaningful carry and overflow.
  function automatic logic is_arith(alu_op_e op);
    return (op == OpAdd) || (op == OpSub);
  endfunction

endpackage

// File: rtl/alu_bit_sequencer_if.sv
// Request/result bundle between a client and the bit-serial ALU sequencer.
interface alu_bit_sequencer_if #(
  parameter int unsigned WIDTH = 64
);
  logic             start;
  logic             ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       cntrl;
  logic [WIDTH-1:0] result;
  logic             done;
  logic             negative;
  logic             zero;
  logic             overflow;
  logic             carry_out;

  modport master (
    output start, a, b, cntrl,
    input  ready, result, done, negative, zero, overflow, carry_out
  );

  modport slave (
    input  start, a, b, cntrl,
    output ready, result, done, negative, zero, overflow, carry_out
  );
endinterface

// File: rtl/alu_seq_flags.sv
// Result flag registers, captured on the MSB write of an operation.
// Present only when ALU_SEQ_FLAGS_EN is defined; otherwise all flags are tied low.
module alu_seq_flags
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             update,
  input  alu_op_e          op,
  input  logic             msb_cin,
  input  logic             msb_cout,
  input  logic [WIDTH-1:0] result,
  output logic             negative,
  output logic             zero,
  output logic             overflow,
  output logic             carry_out
);

`ifdef ALU_SEQ_FLAGS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      negative  <= 1'b0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
      carry_out <= 1'b0;
    end else if (update) begin
      negative  <= result[WIDTH-1];
      zero      <= (result == '0);
      overflow  <= is_arith(op) ? (msb_cin ^ msb_cout) : 1'b0;
      carry_out <= is_arith(op) ? msb_cout : 1'b0;
    end
  end
`else
  assign negative  = 1'b0;
  assign zero      = 1'b0;
  assign overflow  = 1'b0;
  assign carry_out = 1'b0;

  logic unused_flag_inputs;
  assign unused_flag_inputs = ^{clk, reset, update, op, msb_cin, msb_cout, result};
`endif

endmodule

// File: rtl/alu_bit_sequencer.sv
// Bit-serial ALU sequencer driving an external 1-bit slice, LSB first.
// Flag logic lives in alu_seq_flags and is enabled by ALU_SEQ_FLAGS_EN.
module alu_bit_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 64
) (
  input  logic                clk,
  input  logic                reset,
  alu_bit_sequencer_if.slave  bus,
  output logic                slice_a,
  output logic                slice_b,
  output logic                slice_cin,
  output logic [2:0]          slice_en,
  input  logic                slice_out,
  input  logic                slice_cout
);

  localparam int unsigned IdxW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  seq_state_e       state_q;
  alu_op_e          op_q;
  logic [IdxW-1:0]  idx_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] result_nxt;
  logic             carry_q;
  logic             primed_q;
  logic             done_q;
  logic             run;
  logic             msb_write;

  assign run       = (state_q == StRun);
  assign msb_write = run && primed_q && (idx_q == IdxW'(WIDTH - 1));

  always_comb begin
    result_nxt        = result_q;
    result_nxt[idx_q] = slice_out;
  end

  // The first RUN cycle only presents bit 0 to the slice; capture starts on the next edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      op_q     <= OpPassB;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      primed_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.start) begin
            a_q      <= bus.a;
            b_q      <= bus.b;
            op_q     <= alu_op_e'(bus.cntrl);
            idx_q    <= '0;
            carry_q  <= (alu_op_e'(bus.cntrl) == OpSub);
            primed_q <= 1'b0;
            result_q <= '0;
            state_q  <= StRun;
          end
        end
        StRun: begin
          if (!primed_q) begin
            primed_q <= 1'b1;
          end else begin
            result_q <= result_nxt;
            carry_q  <= slice_cout;
            if (msb_write) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.ready  = (state_q == StIdle);
  assign bus.done   = done_q;
  assign bus.result = result_q;

  assign slice_a   = run & a_q[idx_q];
  assign slice_b   = run & b_q[idx_q];
  assign slice_cin = run & carry_q;
  assign slice_en  = run ? op_q : 3'b000;

  alu_seq_flags #(
    .WIDTH(WIDTH)
  ) u_flags (
    .clk      (clk),
    .reset    (reset),
    .update   (msb_write),
    .op       (op_q),
    .msb_cin  (carry_q),
    .msb_cout (slice_cout),
    .result   (result_nxt),
    .negative (bus.negative),
    .zero     (bus.zero),
    .overflow (bus.overflow),
    .carry_out(bus.carry_out)
  );

endmodule
